acsi_multi: RTL and testbench

ACSI_MULTI -- requirements
Module: acsi_multi

---
 rtl/acsi_pkg.sv | 44 ++++
 rtl/acsi_reply_rom.sv | 68 ++++++
 rtl/acsi_multi.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_acsi_multi.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/acsi_pkg.sv
// Shared definitions for the multi-target ACSI command engine: opcodes,
// additional sense codes, FSM encodings and the command-length rule.
package acsi_pkg;

  localparam logic [7:0] OP_TEST_UNIT_READY = 8'h00;
  localparam logic [7:0] OP_REQUEST_SENSE   = 8'h03;
  localparam logic [7:0] OP_READ6           = 8'h08;
  localparam logic [7:0] OP_WRITE6          = 8'h0A;
  localparam logic [7:0] OP_SEEK6           = 8'h0B;
  localparam logic [7:0] OP_INQUIRY         = 8'h12;
  localparam logic [7:0] OP_MODE_SENSE6     = 8'h1A;
  localparam logic [7:0] OP_READ_CAPACITY   = 8'h25;
  localparam logic [7:0] OP_READ10          = 8'h28;
  localparam logic [7:0] OP_WRITE10         = 8'h2A;
  localparam logic [7:0] OP_SEEK10          = 8'h2B;
  localparam logic [7:0] OP_REPORT_LUNS     = 8'hA0;

  // First-byte opcode field that escapes to an extended (ICD) command
  localparam logic [4:0] OP_ICD_ESC = 5'h1F;

  localparam logic [7:0] ASC_NONE           = 8'h00;
  localparam logic [7:0] ASC_INVALID_OPCODE = 8'h20;
  localparam logic [7:0] ASC_LBA_RANGE      = 8'h21;
  localparam logic [7:0] ASC_INVALID_LUN    = 8'h25;

  localparam logic [7:0] SENSE_KEY_ILLEGAL  = 8'h05;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_CMD       = 3'd1;
  localparam state_t ST_REPLY     = 3'd2;
  localparam state_t ST_XFER_REQ  = 3'd3;
  localparam state_t ST_XFER_WAIT = 3'd4;

  function automatic logic [4:0] cmd_len(input logic [7:0] op);
    logic [4:0] len;
    len = 5'd6;
    if (op >= 8'h20 && op <= 8'h5F) len = 5'd10;
    else if (op >= 8'h80 && op <= 8'h9F) len = 5'd16;
    else if (op >= 8'hA0 && op <= 8'hBF) len = 5'd12;
    return len;
  endfunction

endpackage

// File: rtl/acsi_reply_rom.sv
// Reply word generator for the data-returning commands; purely combinational,
// indexed by opcode and 16-bit word position.
module acsi_reply_rom
  import acsi_pkg::*;
(
  input  logic [7:0]  opcode,
  input  logic [7:0]  word_idx,
  input  logic [22:0] blocks,
  input  logic [7:0]  asc,
  output logic [15:0] data
);

  logic [31:0] last_lba;
  logic [23:0] blk24;

  assign last_lba = {9'b0, blocks} - 32'd1;
  assign blk24    = {1'b0, blocks};

  always_comb begin
    data = '0;
    case (opcode)
      OP_REQUEST_SENSE: begin
        case (word_idx)
          8'd0: data = 16'h7000;
          8'd1: data = {(asc != ASC_NONE) ? SENSE_KEY_ILLEGAL : 8'h00, 8'h00};
          8'd3: data = 16'h000B;
          8'd6: data = {asc, 8'h00};
          default: data = '0;
        endcase
      end
      OP_INQUIRY: begin
        case (word_idx)
          8'd0, 8'd3: data = '0;
          8'd1: data = 16'h0100;
          8'd2: data = 16'h1F00;
          8'd4: data = 16'h4143;
          8'd5: data = 16'h5349;
          8'd8: data = 16'h5344;
          // remaining vendor/product/revision text is space padded
          default: data = (word_idx < 8'd18) ? 16'h2020 : 16'h0000;
        endcase
      end
      OP_MODE_SENSE6: begin
        case (word_idx)
          8'd0: data = 16'h0F00;
          8'd1: data = 16'h0008;
          8'd2: data = {8'h00, blk24[23:16]};
          8'd3: data = blk24[15:0];
          8'd5: data = 16'h0200;
          default: data = '0;
        endcase
      end
      OP_READ_CAPACITY: begin
        case (word_idx)
          8'd0: data = last_lba[31:16];
          8'd1: data = last_lba[15:0];
          8'd3: data = 16'h0200;
          default: data = '0;
        endcase
      end
      OP_REPORT_LUNS: begin
        if (word_idx == 8'd1) data = 16'h0008;
      end
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/acsi_multi.sv
// ACSI command engine serving several SD-backed targets: collects command
// bytes from the CPU port, then streams sector requests or reply words.
module acsi_multi
  import acsi_pkg::*;
#(
  parameter int NUM_TARGETS = 2,
  parameter int MAX_SECTORS = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic [7:0]               enable,
  input  logic [NUM_TARGETS*32-1:0] img_size,
  output logic [NUM_TARGETS-1:0]   data_rd_req,
  output logic [NUM_TARGETS-1:0]   data_wr_req,
  output logic [31:0]              data_lba,
  input  logic                     data_busy,
  input  logic                     sector_done,
  input  logic                     cpu_a1,
  input  logic                     cpu_sel,
  input  logic                     cpu_rw,
  input  logic [7:0]               cpu_din,
  output logic [7:0]               cpu_dout,
  output logic [15:0]              reply_data,
  output logic                     reply_req,
  input  logic                     reply_ack,
  output logic                     irq
);

  state_t      state;
  logic [2:0]  target;
  logic [3:0]  idx;
  logic [7:0]  cmd [9];
  logic        err;
  logic        sel_d;
  logic [16:0] remaining;
  logic        xfer_write;
  logic [7:0]  reply_len;
  logic [7:0]  word_idx;
  logic [7:0]  asc [NUM_TARGETS];

  logic        access, cpu_wr, start_cmd, tgt_ok, cmd_byte, last_byte, execute;
  logic [2:0]  new_tgt;
  logic [4:0]  cur_len;
  logic [7:0]  cb [9];
  logic [31:0] img_cur;
  logic [22:0] blocks_cur;
  logic [7:0]  asc_cur;
  logic [NUM_TARGETS-1:0] onehot;
  logic        unused_bits;

  assign access    = clk_en & cpu_sel & ~sel_d;
  assign cpu_wr    = access & ~cpu_rw;
  assign new_tgt   = cpu_din[7:5];
  assign tgt_ok    = (32'(new_tgt) < NUM_TARGETS) && enable[new_tgt];
  assign start_cmd = cpu_wr & ~cpu_a1 & tgt_ok;
  assign cmd_byte  = cpu_wr & cpu_a1 & (state == ST_CMD);
  assign cpu_dout  = {6'b0, err, 1'b0};

  always_comb begin
    img_cur = '0;
    asc_cur = '0;
    onehot  = '0;
    for (int unsigned t = 0; t < NUM_TARGETS; t++) begin
      if (t == 32'(target)) begin
        img_cur   = img_size[t*32 +: 32];
        asc_cur   = asc[t];
        onehot[t] = 1'b1;
      end
    end
  end
  assign blocks_cur = img_cur[31:9];

  // Command bytes as they will look once the byte being written lands
  always_comb begin
    for (int unsigned i = 0; i < 9; i++) cb[i] = cmd[i];
    if (cmd_byte && idx < 4'd9) cb[idx] = cpu_din;
  end

  // idx 0 only occurs after an ICD escape, where this byte is the opcode
  assign cur_len   = (idx == 4'd0) ? cmd_len(cpu_din) : cmd_len(cmd[0]);
  assign last_byte = ({1'b0, idx} + 5'd1) == cur_len;
  assign execute   = cmd_byte & last_byte;
  assign unused_bits = ^{img_cur[8:0], cb[6]};

  logic        supported, lun_chk, is_rw, is_write, is_reply;
  logic [31:0] xlba;
  logic [16:0] xcnt;
  logic [7:0]  rep_words;
  logic        range_bad;
  logic        exec_err, exec_done, exec_xfer, exec_reply;
  logic [7:0]  err_asc;

  always_comb begin
    supported = 1'b0;
    lun_chk   = 1'b0;
    is_rw     = 1'b0;
    is_write  = 1'b0;
    is_reply  = 1'b0;
    xlba      = '0;
    xcnt      = '0;
    rep_words = '0;
    case (cb[0])
      OP_TEST_UNIT_READY, OP_SEEK6, OP_SEEK10: begin
        supported = 1'b1;
        lun_chk   = 1'b1;
      end
      OP_READ6, OP_WRITE6: begin
        supported = 1'b1;
        lun_chk   = 1'b1;
        is_rw     = 1'b1;
        is_write  = (cb[0] == OP_WRITE6);
        xlba      = {11'b0, cb[1][4:0], cb[2], cb[3]};
        xcnt      = (cb[4] == 8'd0) ? 17'd256 : {9'b0, cb[4]};
      end
      OP_READ10, OP_WRITE10: begin
        supported = 1'b1;
        lun_chk   = 1'b1;
        is_rw     = 1'b1;
        is_write  = (cb[0] == OP_WRITE10);
        xlba      = {cb[2], cb[3], cb[4], cb[5]};
        xcnt      = {1'b0, cb[7], cb[8]};
      end
      OP_REQUEST_SENSE, OP_INQUIRY: begin
        supported = 1'b1;
        is_reply  = 1'b1;
        rep_words = {1'b0, cb[4][7:1]};
      end
      OP_MODE_SENSE6, OP_REPORT_LUNS: begin
        supported = 1'b1;
        is_reply  = 1'b1;
        rep_words = 8'd8;
      end
      OP_READ_CAPACITY: begin
        supported = 1'b1;
        is_reply  = 1'b1;
        rep_words = 8'd4;
      end
      default: ;
    endcase
  end

  assign range_bad = (({1'b0, xlba} + {16'b0, xcnt}) > {10'b0, blocks_cur}) ||
                     ({15'b0, xcnt} > 32'(MAX_SECTORS));

  always_comb begin
    exec_err   = 1'b0;
    exec_done  = 1'b0;
    exec_xfer  = 1'b0;
    exec_reply = 1'b0;
    err_asc    = ASC_NONE;
    if (!supported) begin
      exec_err = 1'b1;
      err_asc  = ASC_INVALID_OPCODE;
    end else if (lun_chk && cb[1][7:5] != 3'd0) begin
      exec_err = 1'b1;
      err_asc  = ASC_INVALID_LUN;
    end else if (is_rw) begin
      if (xcnt == '0) exec_done = 1'b1;
      else if (range_bad) begin
        exec_err = 1'b1;
        err_asc  = ASC_LBA_RANGE;
      end else exec_xfer = 1'b1;
    end else if (is_reply) begin
      if (rep_words == '0) exec_done = 1'b1;
      else exec_reply = 1'b1;
    end else begin
      exec_done = 1'b1;
    end
  end

  logic fsm_go, xfer_last, reply_last, asc_wr;
  logic [7:0] asc_val;

  assign fsm_go     = ~start_cmd & ~cmd_byte;
  assign xfer_last  = fsm_go && state == ST_XFER_WAIT && sector_done && remaining <= 17'd1;
  assign reply_last = fsm_go && state == ST_REPLY && reply_ack &&
                      word_idx == reply_len - 8'd1;
  assign asc_wr     = (execute && (exec_err || exec_done)) || xfer_last || reply_last;
  assign asc_val    = (execute && exec_err) ? err_asc : ASC_NONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned t = 0; t < NUM_TARGETS; t++) asc[t] <= '0;
    end else if (asc_wr) begin
      for (int unsigned t = 0; t < NUM_TARGETS; t++)
        if (t == 32'(target)) asc[t] <= asc_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      target      <= '0;
      idx         <= '0;
      for (int unsigned i = 0; i < 9; i++) cmd[i] <= '0;
      err         <= 1'b0;
      irq         <= 1'b0;
      sel_d       <= 1'b0;
      remaining   <= '0;
      xfer_write  <= 1'b0;
      reply_len   <= '0;
      word_idx    <= '0;
      reply_req   <= 1'b0;
      data_lba    <= '0;
      data_rd_req <= '0;
      data_wr_req <= '0;
    end else begin
      if (clk_en) sel_d <= cpu_sel;
      if (access) irq <= 1'b0;
      if (start_cmd) begin
        // A new first byte always wins, aborting any reply or transfer
        target      <= new_tgt;
        err         <= 1'b0;
        data_rd_req <= '0;
        data_wr_req <= '0;
        reply_req   <= 1'b0;
        irq         <= 1'b1;
        state       <= ST_CMD;
        if (cpu_din[4:0] == OP_ICD_ESC) idx <= 4'd0;
        else begin
          cmd[0] <= {3'b0, cpu_din[4:0]};
          idx    <= 4'd1;
        end
      end else if (cmd_byte) begin
        if (idx < 4'd9) cmd[idx] <= cpu_din;
        if (last_byte) begin
          state <= ST_IDLE;
          if (exec_err) begin
            err <= 1'b1;
            irq <= 1'b1;
          end
          if (exec_done) irq <= 1'b1;
          if (exec_xfer) begin
            state       <= ST_XFER_REQ;
            data_lba    <= xlba;
            remaining   <= xcnt;
            xfer_write  <= is_write;
            data_rd_req <= is_write ? '0 : onehot;
            data_wr_req <= is_write ? onehot : '0;
          end
          if (exec_reply) begin
            state     <= ST_REPLY;
            reply_req <= 1'b1;
            word_idx  <= '0;
            reply_len <= rep_words;
          end
        end else begin
          idx <= idx + 4'd1;
          irq <= 1'b1;
        end
      end else begin
        case (state)
          ST_XFER_REQ: begin
            if (data_busy) begin
              data_rd_req <= '0;
              data_wr_req <= '0;
              state       <= ST_XFER_WAIT;
            end
          end
          ST_XFER_WAIT: begin
            if (sector_done) begin
              remaining <= remaining - 17'd1;
              data_lba  <= data_lba + 32'd1;
              if (remaining > 17'd1) begin
                state       <= ST_XFER_REQ;
                data_rd_req <= xfer_write ? '0 : onehot;
                data_wr_req <= xfer_write ? onehot : '0;
              end else begin
                state <= ST_IDLE;
                irq   <= 1'b1;
              end
            end
          end
          ST_REPLY: begin
            if (reply_ack) begin
              if (reply_last) begin
                reply_req <= 1'b0;
                state     <= ST_IDLE;
                irq       <= 1'b1;
              end else word_idx <= word_idx + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  acsi_reply_rom u_rom (
    .opcode   (cmd[0]),
    .word_idx (word_idx),
    .blocks   (blocks_cur),
    .asc      (asc_cur),
    .data     (reply_data)
  );

endmodule

// File: tb/tb_acsi_multi.sv
// Directed bench for acsi_multi with four targets of 1 MiB each.
module tb_acsi_multi;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clk_en = 1'b1;
  logic [7:0]   enable = 8'b0010_0011;
  logic [127:0] img_size = {4{32'h0010_0000}};
  logic [3:0]   data_rd_req, data_wr_req;
  logic [31:0]  data_lba;
  logic         data_busy = 1'b0;
  logic         sector_done = 1'b0;
  logic         cpu_a1 = 1'b0, cpu_sel = 1'b0, cpu_rw = 1'b1;
  logic [7:0]   cpu_din = '0;
  logic [7:0]   cpu_dout;
  logic [15:0]  reply_data;
  logic         reply_req;
  logic         reply_ack = 1'b0;
  logic         irq;

  int checks = 0;
  int errors = 0;

  acsi_multi #(.NUM_TARGETS(4), .MAX_SECTORS(256)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .enable(enable), .img_size(img_size),
    .data_rd_req(data_rd_req), .data_wr_req(data_wr_req), .data_lba(data_lba),
    .data_busy(data_busy), .sector_done(sector_done),
    .cpu_a1(cpu_a1), .cpu_sel(cpu_sel), .cpu_rw(cpu_rw), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .reply_data(reply_data), .reply_req(reply_req),
    .reply_ack(reply_ack), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_acc(input logic a1, input logic rw, input logic [7:0] d);
    @(posedge clk); #1;
    cpu_a1 = a1; cpu_rw = rw; cpu_din = d; cpu_sel = 1'b1;
    @(posedge clk); #1;
    cpu_sel = 1'b0;
  endtask

  // rest holds the following bytes left-aligned, first byte in bits 79:72
  task automatic send_cmd(input logic [7:0] b0, input logic [79:0] rest, input int n);
    cpu_acc(1'b0, 1'b0, b0);
    for (int i = 0; i < n; i++) cpu_acc(1'b1, 1'b0, rest[79-8*i -: 8]);
  endtask

  task automatic pulse_busy();
    @(posedge clk); #1 data_busy = 1'b1;
    @(posedge clk); #1 data_busy = 1'b0;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 sector_done = 1'b1;
    @(posedge clk); #1 sector_done = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // kind 0: request sense, 1: inquiry (word 1 only), 2: read capacity of 2048 blocks
  function automatic logic [16:0] exp_word(input int kind, input int i, input logic [7:0] asc);
    logic [16:0] r;
    r = '0;
    case (kind)
      0: case (i)
           0: r = {1'b1, 16'h7000};
           1: r = {1'b1, (asc != 8'h00) ? 16'h0500 : 16'h0000};
           3: r = {1'b1, 16'h000B};
           6: r = {1'b1, asc, 8'h00};
           default: r = {1'b1, 16'h0000};
         endcase
      1: if (i == 1) r = {1'b1, 16'h0100};
      2: case (i)
           1: r = {1'b1, 16'h07FF};
           3: r = {1'b1, 16'h0200};
           default: r = {1'b1, 16'h0000};
         endcase
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic walk_reply(input string tag, input int n, input int kind, input logic [7:0] asc);
    logic [16:0] e;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_req"}, {31'b0, reply_req}, 32'd1);
      e = exp_word(kind, i, asc);
      if (e[16]) chk($sformatf("%s_w%0d", tag, i), {16'b0, reply_data}, {16'b0, e[15:0]});
      @(posedge clk); #1 reply_ack = 1'b1;
      @(posedge clk); #1 reply_ack = 1'b0;
    end
    chk({tag, "_req_done"}, {31'b0, reply_req}, 32'd0);
    chk({tag, "_irq"}, {31'b0, irq}, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_rd", {28'b0, data_rd_req}, 32'd0);
    chk("rst_wr", {28'b0, data_wr_req}, 32'd0);
    chk("rst_lba", data_lba, 32'd0);
    chk("rst_reply_req", {31'b0, reply_req}, 32'd0);
    chk("rst_dout", {24'b0, cpu_dout}, 32'd0);

    // read(6) target 1, LBA 10, 3 sectors
    send_cmd(8'h28, {40'h00_00_0A_03_00, 40'h0}, 5);
    chk("r6_irq_start", {31'b0, irq}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("r6_rd%0d", i), {28'b0, data_rd_req}, 32'h2);
      chk($sformatf("r6_wr%0d", i), {28'b0, data_wr_req}, 32'h0);
      chk($sformatf("r6_lba%0d", i), data_lba, 32'd10 + 32'(i));
      pulse_busy();
      chk($sformatf("r6_rd_clr%0d", i), {28'b0, data_rd_req}, 32'h0);
      pulse_done();
      chk($sformatf("r6_irq%0d", i), {31'b0, irq}, (i == 2) ? 32'd1 : 32'd0);
    end
    chk("r6_rd_end", {28'b0, data_rd_req}, 32'h0);

    // unsupported opcode 05 on target 1
    send_cmd(8'h25, {40'h0, 40'h0}, 5);
    chk("bad_op_err", {24'b0, cpu_dout}, 32'h02);
    chk("bad_op_irq", {31'b0, irq}, 32'd1);

    // read(10) target 0, LBA 2047 count 2 exceeds 2048 blocks
    send_cmd(8'h1F, 80'h28_00_00_00_07_FF_00_00_02_00, 10);
    chk("range_err", {24'b0, cpu_dout}, 32'h02);
    chk("range_irq", {31'b0, irq}, 32'd1);
    chk("range_rd", {28'b0, data_rd_req}, 32'h0);
    send_cmd(8'h03, {40'h00_00_00_16_00, 40'h0}, 5);
    chk("sense0_err_clr", {24'b0, cpu_dout}, 32'h00);
    walk_reply("sense_t0", 11, 0, 8'h21);

    // inquiry alloc 36 on target 0, then target 1 sense keeps its own ASC
    send_cmd(8'h12, {40'h00_00_00_24_00, 40'h0}, 5);
    walk_reply("inquiry", 18, 1, 8'h00);
    send_cmd(8'h23, {40'h00_00_00_0E_00, 40'h0}, 5);
    walk_reply("sense_t1", 7, 0, 8'h20);

    // target 5 is outside NUM_TARGETS: ignored, follow-up byte also ignored
    cpu_acc(1'b0, 1'b0, 8'hA0);
    chk("t5_irq", {31'b0, irq}, 32'd0);
    cpu_acc(1'b1, 1'b0, 8'h00);
    chk("t5_irq_after", {31'b0, irq}, 32'd0);
    chk("t5_reply_req", {31'b0, reply_req}, 32'd0);

    // read capacity on 1 MiB target: last LBA 2047, block size 512
    send_cmd(8'h1F, 80'h25_00_00_00_00_00_00_00_00_00, 10);
    walk_reply("rdcap", 4, 2, 8'h00);

    // read(10) with count 0 completes immediately without error
    send_cmd(8'h1F, 80'h28_00_00_00_00_05_00_00_00_00, 10);
    chk("cnt0_irq", {31'b0, irq}, 32'd1);
    chk("cnt0_err", {24'b0, cpu_dout}, 32'h00);
    chk("cnt0_rd", {28'b0, data_rd_req}, 32'h0);

    // non-zero LUN on read(6)
    send_cmd(8'h08, {40'h20_00_00_01_00, 40'h0}, 5);
    chk("lun_err", {24'b0, cpu_dout}, 32'h02);
    chk("lun_irq", {31'b0, irq}, 32'd1);
    send_cmd(8'h03, {40'h00_00_00_0E_00, 40'h0}, 5);
    walk_reply("sense_lun", 7, 0, 8'h25);

    // abort a write(6) in XFER_WAIT; stale sector_done must be ignored
    send_cmd(8'h2A, {40'h00_00_00_02_00, 40'h0}, 5);
    chk("ab_wr", {28'b0, data_wr_req}, 32'h2);
    chk("ab_rd", {28'b0, data_rd_req}, 32'h0);
    pulse_busy();
    chk("ab_wr_wait", {28'b0, data_wr_req}, 32'h0);
    cpu_acc(1'b0, 1'b0, 8'h00);
    chk("ab_wr_clr", {28'b0, data_wr_req}, 32'h0);
    pulse_done();
    chk("ab_lba_hold", data_lba, 32'd0);
    chk("ab_wr_hold", {28'b0, data_wr_req}, 32'h0);
    send_cmd(8'h00, {40'h0, 40'h0}, 0);
    for (int i = 0; i < 5; i++) cpu_acc(1'b1, 1'b0, 8'h00);
    chk("ab_tur_irq", {31'b0, irq}, 32'd1);
    chk("ab_tur_lba", data_lba, 32'd0);

    // reset during REPLY
    send_cmd(8'h12, {40'h00_00_00_04_00, 40'h0}, 5);
    chk("rr_req_pre", {31'b0, reply_req}, 32'd1);
    pulse_reset();
    chk("rr_req", {31'b0, reply_req}, 32'd0);
    chk("rr_irq", {31'b0, irq}, 32'd0);

    // reset while a read request is outstanding
    send_cmd(8'h08, {40'h00_00_05_01_00, 40'h0}, 5);
    chk("rx_rd_pre", {28'b0, data_rd_req}, 32'h1);
    chk("rx_lba_pre", data_lba, 32'd5);
    pulse_reset();
    chk("rx_rd", {28'b0, data_rd_req}, 32'h0);
    chk("rx_lba", data_lba, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
